lrn_glb_arbiter: RTL and testbench
==================================

Name: lrn_glb_arbiter

Overview:
- Shares the single-port global buffer (GLB) between the LRN mapper's read stream and its write stream.
- Each requester gets a one-entry holding register. The arbiter picks one request per cycle, issues a registered GLB command, and returns read data through a latency-matched valid pipeline.
- Sits between the LRN mapper/normalizer and the GLB SRAM macro.

Parameters:
- ADDR_BUS_WIDTH, 20, GLB address width
- DATA_WIDTH, 16, GLB word width
- READ_LAT, 1, cycles from GLB command cycle to glb_rdata valid (1..4)

Ports:
- core_clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- rd_req  in  1  read request
- rd_addr  in  ADDR_BUS_WIDTH  read address
- rd_ready  out  1  read holding register can accept
- rd_data  out  DATA_WIDTH  returned read word
- rd_valid  out  1  rd_data valid, single-cycle pulse per read
- wr_req  in  1  write request
- wr_addr  in  ADDR_BUS_WIDTH  write address
- wr_data  in  DATA_WIDTH  write word
- wr_ready  out  1  write holding register can accept
- glb_en  out  1  GLB access strobe
- glb_we  out  1  1 = write, 0 = read
- glb_addr  out  ADDR_BUS_WIDTH  GLB address
- glb_wdata  out  DATA_WIDTH  GLB write data
- glb_rdata  in  DATA_WIDTH  GLB read data
- busy  out  1  any request pending or read in flight

Behaviour:
- Reset (reset=0, async):
  - All pending flags 0; glb_en, glb_we, rd_valid, busy = 0.
  - glb_addr, glb_wdata, rd_data = 0.
  - Round-robin pointer last_grant = WRITE, so the first conflict goes to read.
- Accept rule: a request is captured into its holding register (addr/data + pending=1) at an edge where req && ready.
  - rd_ready = !rd_pend || rd_grant; wr_ready likewise (combinational).
  - Each port sustains one access per cycle when uncontested.
- Grant, combinational, per cycle:
  - Neither pending: no grant.
  - One pending: that one is granted.
  - Both pending and rd addr == wr addr: write granted regardless of pointer (read-after-write ordering).
  - Both pending, other cases: grant the port opposite last_grant; last_grant updates on each grant (including single-pending grants).
- Issue: at the edge ending the grant cycle, glb_en=1, glb_we, glb_addr and glb_wdata are registered from the granted holding register, and that port's pending clears unless a new accept occurs on the same edge.
  - glb_en=0 in any cycle following a no-grant cycle.
  - glb_wdata holds its last value on reads.
- Latency: request accepted at edge E0 → glb_en high in the cycle after E1 → for reads, glb_rdata is sampled READ_LAT cycles after the glb_en cycle and registered to rd_data, with rd_valid high one cycle later.
  - Uncontested read: rd_valid rises READ_LAT+2 cycles after acceptance.
  - An in-flight shift register of depth READ_LAT tracks reads.
  - Reads return in issue order; no backpressure on rd_valid.
- busy = rd_pend || wr_pend || any in-flight bit || glb_en.
- Simultaneous events: an accept and a grant on the same port in the same cycle keep pending=1 with the new contents.
- Writes never produce a response.
- Mid-operation reset discards pending requests and in-flight reads; no rd_valid is emitted after reset deassertion for pre-reset reads.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds output conflict_count [15:0], reset 0. It increments on every cycle where both ports are pending and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single read, READ_LAT=1: rd_req addr 0x00010, GLB returns 0xBEEF → glb_en=1/glb_we=0/glb_addr=0x00010 one cycle after accept; rd_valid=1 with rd_data=0xBEEF 3 cycles after accept; busy low afterwards.
- Conflict after reset: read 0x00020 and write 0x00030/0x1234 accepted same edge → read issued first, write next cycle; conflict_count=1 with ARB_STATS_EN.
- Same-address hazard: read and write both to 0x00040, data 0x5555 → write issued first, then read; the GLB model returns 0x5555.
- Streaming: wr_req held 8 cycles with no reads → wr_ready stays 1 and glb_en is high 8 consecutive cycles with sequential addresses.
- Mid-flight reset: read issued, reset pulled low before data returns → all outputs 0 immediately; no rd_valid after release.
- READ_LAT=3: 4 back-to-back reads → 4 rd_valid pulses in order, each 5 cycles after its accept.

Source files
------------

// File: rtl/lrn_glb_arbiter.sv
// ---------------------------------------------------------------------------
// lrn_glb_arbiter
//
// Shares the single-port global buffer (GLB) SRAM between the LRN mapper's
// read stream and write stream. Each stream has a one-entry holding register.
// One holding register is granted per cycle and issued as a registered GLB
// command. Read data comes back through an in-flight pipeline that is matched
// to the SRAM read latency.
//
// Optional build macro: ARB_STATS_EN. It adds the conflict_count output.
//
// Parameters
//   ADDR_BUS_WIDTH  GLB address width
//   DATA_WIDTH      GLB word width
//   READ_LAT        cycles from the glb_en cycle to glb_rdata valid (1..4)
//
// Ports
//   core_clk        clock, rising edge
//   reset           asynchronous active-low reset
//   rd_req/rd_addr  read request; accepted when rd_req && rd_ready
//   rd_ready        read holding register can accept this cycle
//   rd_data         returned read word, valid with rd_valid
//   rd_valid        one-cycle pulse per returned read, in issue order
//   wr_req/wr_addr/wr_data  write request; accepted when wr_req && wr_ready
//   wr_ready        write holding register can accept this cycle
//   glb_en/glb_we/glb_addr/glb_wdata  registered GLB command
//   glb_rdata       GLB read data, READ_LAT cycles after the glb_en cycle
//   busy            a request is pending, a read is in flight, or a command is out
//   conflict_count  (ARB_STATS_EN only) count of cycles with both ports
//                   pending; saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module lrn_glb_arbiter #(
  parameter int ADDR_BUS_WIDTH = 20,
  parameter int DATA_WIDTH     = 16,
  parameter int READ_LAT       = 1
) (
  input  logic                      core_clk,
  input  logic                      reset,
  input  logic                      rd_req,
  input  logic [ADDR_BUS_WIDTH-1:0] rd_addr,
  output logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  input  logic                      wr_req,
  input  logic [ADDR_BUS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_ready,
  output logic                      glb_en,
  output logic                      glb_we,
  output logic [ADDR_BUS_WIDTH-1:0] glb_addr,
  output logic [DATA_WIDTH-1:0]     glb_wdata,
  input  logic [DATA_WIDTH-1:0]     glb_rdata,
  output logic                      busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]               conflict_count
`endif
);

  // Port identifier used by the round-robin pointer.
  typedef enum logic {
    PORT_RD = 1'b0,
    PORT_WR = 1'b1
  } port_e;

  // Holding registers.
  logic                      r_rd_pend;
  logic [ADDR_BUS_WIDTH-1:0] r_rd_addr;
  logic                      r_wr_pend;
  logic [ADDR_BUS_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]     r_wr_data;

  // Round-robin state.
  port_e r_last_grant;
  port_e w_last_grant_nxt;

  // GLB command and read return registers.
  logic                      r_glb_en;
  logic                      r_glb_we;
  logic [ADDR_BUS_WIDTH-1:0] r_glb_addr;
  logic [DATA_WIDTH-1:0]     r_glb_wdata;
  logic [READ_LAT-1:0]       r_inflight;
  logic                      r_rd_valid;
  logic [DATA_WIDTH-1:0]     r_rd_data;

  logic w_rd_grant;
  logic w_wr_grant;
  logic w_rd_accept;
  logic w_wr_accept;
  logic w_rd_issued;

  // -------------------------------------------------------------------------
  // Grant selection and round-robin next state
  // -------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    w_rd_grant       = 1'b0;
    w_wr_grant       = 1'b0;
    w_last_grant_nxt = r_last_grant;
    if (r_rd_pend && r_wr_pend) begin
      // When both ports target the same word, the write goes first. The
      // read that follows then sees the new data.
      if (r_rd_addr == r_wr_addr) begin
        w_wr_grant = 1'b1;
      end else if (r_last_grant == PORT_WR) begin
        w_rd_grant = 1'b1;
      end else begin
        w_wr_grant = 1'b1;
      end
    end else begin
      w_rd_grant = r_rd_pend;
      w_wr_grant = r_wr_pend;
    end
    if (w_rd_grant) begin
      w_last_grant_nxt = PORT_RD;
    end else if (w_wr_grant) begin
      w_last_grant_nxt = PORT_WR;
    end
  end

  // A holding register being drained this cycle can take a new request on
  // the same edge. This keeps one access per cycle per uncontested port.
  assign rd_ready    = !r_rd_pend || w_rd_grant;
  assign wr_ready    = !r_wr_pend || w_wr_grant;
  assign w_rd_accept = rd_req && rd_ready;
  assign w_wr_accept = wr_req && wr_ready;

  // A read command sits on the GLB pins this cycle.
  assign w_rd_issued = r_glb_en && !r_glb_we;

  // -------------------------------------------------------------------------
  // Round-robin pointer register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples pre-edge values, whatever order the blocks evaluate in.
  always_ff @(posedge core_clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= PORT_WR;
    end else begin
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Holding registers: a new accept wins over the drain on the same edge
  // -------------------------------------------------------------------------
  always_ff @(posedge core_clk or negedge reset) begin
    if (!reset) begin
      r_rd_pend <= 1'b0;
      r_rd_addr <= '0;
      r_wr_pend <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_rd_accept) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= rd_addr;
      end else if (w_rd_grant) begin
        r_rd_pend <= 1'b0;
      end
      if (w_wr_accept) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= wr_addr;
        r_wr_data <= wr_data;
      end else if (w_wr_grant) begin
        r_wr_pend <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // GLB command issue
  // -------------------------------------------------------------------------
  always_ff @(posedge core_clk or negedge reset) begin
    if (!reset) begin
      r_glb_en    <= 1'b0;
      r_glb_we    <= 1'b0;
      r_glb_addr  <= '0;
      r_glb_wdata <= '0;
    end else begin
      r_glb_en <= w_rd_grant || w_wr_grant;
      if (w_wr_grant) begin
        r_glb_we    <= 1'b1;
        r_glb_addr  <= r_wr_addr;
        r_glb_wdata <= r_wr_data;
      end else if (w_rd_grant) begin
        // Write data is left as it was on reads.
        r_glb_we   <= 1'b0;
        r_glb_addr <= r_rd_addr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read return: bit k of r_inflight marks a read whose data arrives k+1
  // cycles after its glb_en cycle. The top bit lines up with glb_rdata.
  // -------------------------------------------------------------------------
  always_ff @(posedge core_clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_inflight <= READ_LAT'({r_inflight, w_rd_issued});
      r_rd_valid <= r_inflight[READ_LAT-1];
      if (r_inflight[READ_LAT-1]) begin
        r_rd_data <= glb_rdata;
      end
    end
  end

  assign glb_en    = r_glb_en;
  assign glb_we    = r_glb_we;
  assign glb_addr  = r_glb_addr;
  assign glb_wdata = r_glb_wdata;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign busy      = r_rd_pend || r_wr_pend || (|r_inflight) || r_glb_en;

`ifdef ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Conflict statistics: cycles where both ports wait, saturating
  // -------------------------------------------------------------------------
  logic [15:0] r_conflict_count;

  always_ff @(posedge core_clk or negedge reset) begin
    if (!reset) begin
      r_conflict_count <= '0;
    end else if (r_rd_pend && r_wr_pend && (r_conflict_count != 16'hFFFF)) begin
      r_conflict_count <= r_conflict_count + 16'd1;
    end
  end

  assign conflict_count = r_conflict_count;
`endif

endmodule

// File: tb/tb_lrn_glb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lrn_glb_arbiter
//
// Directed bench for lrn_glb_arbiter. It uses two instances:
//   u_dut1 with READ_LAT=1 runs the single read, conflict, hazard, streaming
//   and mid-flight reset steps.
//   u_dut3 with READ_LAT=3 runs the back-to-back read step.
// A behavioural GLB model sits behind each instance. Expected GLB commands and
// read returns, with the cycle they should appear in, are queued when the
// stimulus is driven. They are popped and compared when the DUT shows them.
// ---------------------------------------------------------------------------
module tb_lrn_glb_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rd_t;

  logic core_clk;
  logic reset;

  // Instance with READ_LAT=1
  logic          rd_req_1, rd_ready_1, rd_valid_1, wr_req_1, wr_ready_1;
  logic          glb_en_1, glb_we_1, busy_1;
  logic [AW-1:0] rd_addr_1, wr_addr_1, glb_addr_1;
  logic [DW-1:0] rd_data_1, wr_data_1, glb_wdata_1, glb_rdata_1;
  // Instance with READ_LAT=3
  logic          rd_req_3, rd_ready_3, rd_valid_3, wr_req_3, wr_ready_3;
  logic          glb_en_3, glb_we_3, busy_3;
  logic [AW-1:0] rd_addr_3, wr_addr_3, glb_addr_3;
  logic [DW-1:0] rd_data_3, wr_data_3, glb_wdata_3, glb_rdata_3;
`ifdef ARB_STATS_EN
  logic [15:0]   conflict_count_1, conflict_count_3;
`endif

  int   cyc;
  int   n_checks;
  int   n_errors;
  cmd_t cmd1_q[$];
  cmd_t cmd3_q[$];
  rd_t  rd1_q[$];
  rd_t  rd3_q[$];

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  lrn_glb_arbiter #(.ADDR_BUS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1)) u_dut1 (
    .core_clk (core_clk),
    .reset    (reset),
    .rd_req   (rd_req_1),
    .rd_addr  (rd_addr_1),
    .rd_ready (rd_ready_1),
    .rd_data  (rd_data_1),
    .rd_valid (rd_valid_1),
    .wr_req   (wr_req_1),
    .wr_addr  (wr_addr_1),
    .wr_data  (wr_data_1),
    .wr_ready (wr_ready_1),
    .glb_en   (glb_en_1),
    .glb_we   (glb_we_1),
    .glb_addr (glb_addr_1),
    .glb_wdata(glb_wdata_1),
    .glb_rdata(glb_rdata_1),
    .busy     (busy_1)
`ifdef ARB_STATS_EN
    ,
    .conflict_count(conflict_count_1)
`endif
  );

  lrn_glb_arbiter #(.ADDR_BUS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(3)) u_dut3 (
    .core_clk (core_clk),
    .reset    (reset),
    .rd_req   (rd_req_3),
    .rd_addr  (rd_addr_3),
    .rd_ready (rd_ready_3),
    .rd_data  (rd_data_3),
    .rd_valid (rd_valid_3),
    .wr_req   (wr_req_3),
    .wr_addr  (wr_addr_3),
    .wr_data  (wr_data_3),
    .wr_ready (wr_ready_3),
    .glb_en   (glb_en_3),
    .glb_we   (glb_we_3),
    .glb_addr (glb_addr_3),
    .glb_wdata(glb_wdata_3),
    .glb_rdata(glb_rdata_3),
    .busy     (busy_3)
`ifdef ARB_STATS_EN
    ,
    .conflict_count(conflict_count_3)
`endif
  );

  // -------------------------------------------------------------------------
  // GLB models: 256 words indexed by addr[7:0]. An unwritten word returns a
  // pattern derived from its address, and 0x00010 returns 0xBEEF. glb_rdata is
  // zero outside its valid cycle, so a mistimed capture shows up.
  // -------------------------------------------------------------------------
  bit [DW-1:0] mem1 [0:255];
  bit          vld1 [0:255];
  bit [DW-1:0] mem3 [0:255];
  bit          vld3 [0:255];
  bit [DW-1:0] pipe1;
  bit [DW-1:0] pipe3 [0:2];

  function automatic logic [DW-1:0] glb_default(input logic [AW-1:0] a);
    return (a == 20'h00010) ? 16'hBEEF : {a[7:0], ~a[7:0]};
  endfunction

  function automatic logic [DW-1:0] read1(input logic [AW-1:0] a);
    return vld1[a[7:0]] ? mem1[a[7:0]] : glb_default(a);
  endfunction

  function automatic logic [DW-1:0] read3(input logic [AW-1:0] a);
    return vld3[a[7:0]] ? mem3[a[7:0]] : glb_default(a);
  endfunction

  always @(posedge core_clk) begin
    pipe1 <= (glb_en_1 && !glb_we_1) ? read1(glb_addr_1) : '0;
    if (glb_en_1 && glb_we_1) begin
      mem1[glb_addr_1[7:0]] <= glb_wdata_1;
      vld1[glb_addr_1[7:0]] <= 1'b1;
    end
  end

  always @(posedge core_clk) begin
    pipe3[0] <= (glb_en_3 && !glb_we_3) ? read3(glb_addr_3) : '0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    if (glb_en_3 && glb_we_3) begin
      mem3[glb_addr_3[7:0]] <= glb_wdata_3;
      vld3[glb_addr_3[7:0]] <= 1'b1;
    end
  end

  assign glb_rdata_1 = pipe1;
  assign glb_rdata_3 = pipe3[2];

  // -------------------------------------------------------------------------
  // Checking helpers
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon1();
    cmd_t c;
    rd_t  r;
    if (glb_en_1) begin
      if (cmd1_q.size() == 0) begin
        check("cmd1_spurious", 32'(glb_en_1), 32'd0);
      end else begin
        c = cmd1_q.pop_front();
        check("cmd1_cycle", 32'(cyc), 32'(c.cyc));
        check("cmd1_we", 32'(glb_we_1), 32'(c.we));
        check("cmd1_addr", 32'(glb_addr_1), 32'(c.addr));
        if (c.we) check("cmd1_wdata", 32'(glb_wdata_1), 32'(c.wdata));
      end
    end
    if (cmd1_q.size() > 0 && cmd1_q[0].cyc < cyc) begin
      check("cmd1_missing", 32'(cyc), 32'(cmd1_q[0].cyc));
      void'(cmd1_q.pop_front());
    end
    if (rd_valid_1) begin
      if (rd1_q.size() == 0) begin
        check("rd1_spurious", 32'(rd_valid_1), 32'd0);
      end else begin
        r = rd1_q.pop_front();
        check("rd1_cycle", 32'(cyc), 32'(r.cyc));
        check("rd1_data", 32'(rd_data_1), 32'(r.data));
      end
    end
    if (rd1_q.size() > 0 && rd1_q[0].cyc < cyc) begin
      check("rd1_missing", 32'(cyc), 32'(rd1_q[0].cyc));
      void'(rd1_q.pop_front());
    end
  endtask

  task automatic mon3();
    cmd_t c;
    rd_t  r;
    if (glb_en_3) begin
      if (cmd3_q.size() == 0) begin
        check("cmd3_spurious", 32'(glb_en_3), 32'd0);
      end else begin
        c = cmd3_q.pop_front();
        check("cmd3_cycle", 32'(cyc), 32'(c.cyc));
        check("cmd3_we", 32'(glb_we_3), 32'(c.we));
        check("cmd3_addr", 32'(glb_addr_3), 32'(c.addr));
      end
    end
    if (cmd3_q.size() > 0 && cmd3_q[0].cyc < cyc) begin
      check("cmd3_missing", 32'(cyc), 32'(cmd3_q[0].cyc));
      void'(cmd3_q.pop_front());
    end
    if (rd_valid_3) begin
      if (rd3_q.size() == 0) begin
        check("rd3_spurious", 32'(rd_valid_3), 32'd0);
      end else begin
        r = rd3_q.pop_front();
        check("rd3_cycle", 32'(cyc), 32'(r.cyc));
        check("rd3_data", 32'(rd_data_3), 32'(r.data));
      end
    end
    if (rd3_q.size() > 0 && rd3_q[0].cyc < cyc) begin
      check("rd3_missing", 32'(cyc), 32'(rd3_q[0].cyc));
      void'(rd3_q.pop_front());
    end
  endtask

  // One clock: advance, then sample #1 after the edge and run the monitors.
  task automatic step();
    @(posedge core_clk);
    cyc++;
    #1;
    mon1();
    mon3();
  endtask

  // Inputs driven now are accepted at edge cyc+1, and the command shows at cyc+2.
  task automatic exp_cmd1(input int at, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    cmd_t c;
    c.cyc = at; c.we = we; c.addr = a; c.wdata = d;
    cmd1_q.push_back(c);
  endtask

  task automatic exp_rd1(input int at, input logic [DW-1:0] d);
    rd_t r;
    r.cyc = at; r.data = d;
    rd1_q.push_back(r);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int c0;
    cyc = 0; n_checks = 0; n_errors = 0;
    reset = 1'b0;
    rd_req_1 = 1'b0; rd_addr_1 = '0; wr_req_1 = 1'b0; wr_addr_1 = '0; wr_data_1 = '0;
    rd_req_3 = 1'b0; rd_addr_3 = '0; wr_req_3 = 1'b0; wr_addr_3 = '0; wr_data_3 = '0;
    step(); step();

    // Reset state
    check("rst_glb_en", 32'(glb_en_1), 32'd0);
    check("rst_glb_we", 32'(glb_we_1), 32'd0);
    check("rst_glb_addr", 32'(glb_addr_1), 32'd0);
    check("rst_glb_wdata", 32'(glb_wdata_1), 32'd0);
    check("rst_rd_valid", 32'(rd_valid_1), 32'd0);
    check("rst_rd_data", 32'(rd_data_1), 32'd0);
    check("rst_busy", 32'(busy_1), 32'd0);
    check("rst_rd_ready", 32'(rd_ready_1), 32'd1);
    check("rst_wr_ready", 32'(wr_ready_1), 32'd1);
`ifdef ARB_STATS_EN
    check("rst_conflicts", 32'(conflict_count_1), 32'd0);
`endif
    reset = 1'b1;
    step();

    // Single read: the command shows 1 cycle after accept, rd_valid 3 after.
    c0 = cyc;
    rd_req_1 = 1'b1; rd_addr_1 = 20'h00010;
    exp_cmd1(c0 + 2, 1'b0, 20'h00010, '0);
    exp_rd1(c0 + 4, 16'hBEEF);
    step();
    rd_req_1 = 1'b0;
    check("single_busy", 32'(busy_1), 32'd1);
    repeat (4) step();
    check("single_idle", 32'(busy_1), 32'd0);
    check("single_hold", 32'(rd_data_1), 32'hBEEF);

    // Fresh reset so that the round-robin pointer points at WRITE again.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Conflict: the read wins first, then the write.
    c0 = cyc;
    rd_req_1 = 1'b1; rd_addr_1 = 20'h00020;
    wr_req_1 = 1'b1; wr_addr_1 = 20'h00030; wr_data_1 = 16'h1234;
    exp_cmd1(c0 + 2, 1'b0, 20'h00020, '0);
    exp_cmd1(c0 + 3, 1'b1, 20'h00030, 16'h1234);
    exp_rd1(c0 + 4, 16'h20DF);
    step();
    rd_req_1 = 1'b0; wr_req_1 = 1'b0;
    check("conflict_wr_blocked", 32'(wr_ready_1), 32'd0);
    repeat (4) step();
`ifdef ARB_STATS_EN
    check("conflict_count_1", 32'(conflict_count_1), 32'd1);
`endif

    // Same-address hazard: the write goes first even though the pointer favours the read.
    c0 = cyc;
    rd_req_1 = 1'b1; rd_addr_1 = 20'h00040;
    wr_req_1 = 1'b1; wr_addr_1 = 20'h00040; wr_data_1 = 16'h5555;
    exp_cmd1(c0 + 2, 1'b1, 20'h00040, 16'h5555);
    exp_cmd1(c0 + 3, 1'b0, 20'h00040, '0);
    exp_rd1(c0 + 5, 16'h5555);
    step();
    rd_req_1 = 1'b0; wr_req_1 = 1'b0;
    check("hazard_rd_blocked", 32'(rd_ready_1), 32'd0);
    repeat (5) step();
`ifdef ARB_STATS_EN
    check("conflict_count_2", 32'(conflict_count_1), 32'd2);
`endif

    // Streaming writes: one command per cycle, wr_ready held high.
    wr_req_1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_addr_1 = 20'h00100 + AW'(i);
      wr_data_1 = 16'hA000 + DW'(i);
      exp_cmd1(cyc + 2, 1'b1, wr_addr_1, wr_data_1);
      check("stream_wr_ready", 32'(wr_ready_1), 32'd1);
      step();
    end
    wr_req_1 = 1'b0;
    repeat (3) step();

    // Mid-flight reset: read on the GLB pins, reset before its data returns.
    rd_req_1 = 1'b1; rd_addr_1 = 20'h00055;
    exp_cmd1(cyc + 2, 1'b0, 20'h00055, '0);
    step();
    rd_req_1 = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("midrst_glb_en", 32'(glb_en_1), 32'd0);
    check("midrst_glb_we", 32'(glb_we_1), 32'd0);
    check("midrst_glb_addr", 32'(glb_addr_1), 32'd0);
    check("midrst_glb_wdata", 32'(glb_wdata_1), 32'd0);
    check("midrst_rd_data", 32'(rd_data_1), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid_1), 32'd0);
    check("midrst_busy", 32'(busy_1), 32'd0);
    step(); step();
    reset = 1'b1;
    repeat (6) step();
    check("midrst_idle", 32'(busy_1), 32'd0);
`ifdef ARB_STATS_EN
    check("midrst_conflicts", 32'(conflict_count_1), 32'd0);
`endif

    // READ_LAT=3: four back-to-back reads, each returns 5 cycles after accept.
    for (int i = 0; i < 4; i++) begin
      cmd_t c;
      rd_t  r;
      rd_req_3 = 1'b1;
      rd_addr_3 = 20'h00200 + AW'(i);
      c.cyc = cyc + 2; c.we = 1'b0; c.addr = rd_addr_3; c.wdata = '0;
      cmd3_q.push_back(c);
      r.cyc = cyc + 6; r.data = {rd_addr_3[7:0], ~rd_addr_3[7:0]};
      rd3_q.push_back(r);
      check("lat3_rd_ready", 32'(rd_ready_3), 32'd1);
      step();
    end
    rd_req_3 = 1'b0;
    repeat (8) step();
    check("lat3_idle", 32'(busy_3), 32'd0);

    // Every expected event must have been seen.
    check("cmd1_drained", 32'(cmd1_q.size()), 32'd0);
    check("rd1_drained", 32'(rd1_q.size()), 32'd0);
    check("cmd3_drained", 32'(cmd3_q.size()), 32'd0);
    check("rd3_drained", 32'(rd3_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
